// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets the IF stage (fetch) and the MEM stage (load/store) share one
//   single-port memory. Only one transaction is in flight at a time. The data
//   port normally wins. A starvation counter forces a fetch grant once
//   STARVE_LIMIT data grants in a row have happened while a fetch was waiting.
//   Every output is registered.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction
//   after TIMEOUT_CYCLES cycles without mem_ready. The abort pulses err
//   together with the owner's x_valid.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   i_req/i_addr                  fetch request
//   i_gnt/i_valid/i_rdata         fetch accept pulse, completion pulse, instruction
//   d_req/d_we/d_addr/d_wdata     data request (d_we=1 store)
//   d_gnt/d_valid/d_rdata         data accept pulse, completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ready
//   mem_ready/mem_rdata           memory completion and read data
//   err                           timeout abort pulse (always 0 without the timeout)
module mem_port_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_valid,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  state_t          state, state_n;
  logic [SW-1:0]   starve_cnt, starve_n;
  logic            mem_req_n, mem_we_n;
  logic [XLEN-1:0] mem_addr_n, mem_wdata_n;
  logic            i_gnt_n, d_gnt_n, i_valid_n, d_valid_n;
  logic [XLEN-1:0] i_rdata_n, d_rdata_n;
  logic            fetch_forced;
  logic            abort;
  logic            err_n;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic          err_q;

  // Counter reads TIMEOUT_CYCLES-1 during the last BUSY cycle that is allowed.
  assign abort = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign err   = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
  assign err            = 1'b0;
`endif

  // With STARVE_LIMIT==0 the counter stays at 0 and data priority is strict.
  assign fetch_forced = (STARVE_LIMIT != 0) && i_req && (starve_cnt == SLIM);

  always_comb begin
    state_n     = state;
    starve_n    = starve_cnt;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    i_gnt_n     = 1'b0;
    d_gnt_n     = 1'b0;
    i_valid_n   = 1'b0;
    d_valid_n   = 1'b0;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_n     = BUSY_D;
          mem_req_n   = 1'b1;
          mem_we_n    = d_we;
          mem_addr_n  = d_addr;
          mem_wdata_n = d_wdata;
          d_gnt_n     = 1'b1;
          if (i_req && (starve_cnt != SLIM))
            starve_n = starve_cnt + SW'(1);
        end else if (i_req) begin
          state_n     = BUSY_I;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = i_addr;
          mem_wdata_n = '0;
          i_gnt_n     = 1'b1;
          starve_n    = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        // mem_ready takes precedence over an abort on the same edge.
        if (mem_ready || abort) begin
          state_n   = IDLE;
          mem_req_n = 1'b0;
          err_n     = !mem_ready;
          if (state == BUSY_D) begin
            d_valid_n = 1'b1;
            if (!mem_ready)   d_rdata_n = '0;
            else if (!mem_we) d_rdata_n = mem_rdata;
          end else begin
            i_valid_n = 1'b1;
            i_rdata_n = mem_ready ? mem_rdata : '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_comb begin
    tcnt_n = '0;
    if (state != IDLE) tcnt_n = tcnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= tcnt_n;
      err_q <= err_n;
    end
  end
`else
  logic unused_err;

  assign unused_err = err_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      i_gnt      <= i_gnt_n;
      d_gnt      <= d_gnt_n;
      i_valid    <= i_valid_n;
      d_valid    <= d_valid_n;
      i_rdata    <= i_rdata_n;
      d_rdata    <= d_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a scoreboard. Stimulus pushes
// the grants and completions it expects into queues. A monitor running on the
// falling edge pops an entry and compares it each time the DUT pulses a grant
// or a valid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_valid, d_gnt, d_valid;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct { bit is_d; bit we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct { bit is_d; logic [31:0] rdata; bit err; } cmp_t;
  gnt_t gq[$];
  cmp_t cq[$];
  gnt_t mg;
  cmp_t mc;

  logic [31:0] mem [logic [31:0]];
  int lat  = 0;
  int rcnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .XLEN(32),
    .STARVE_LIMIT(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_gnt(input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] w);
    gq.push_back('{is_d, we, a, w});
  endtask

  task automatic exp_cmp(input bit is_d, input logic [31:0] r, input bit e);
    cq.push_back('{is_d, r, e});
  endtask

  task automatic wait_gnt(input bit is_d, input string name);
    int  n = 0;
    logic g;
    do begin
      @(posedge clk); #1;
      n++;
      g = is_d ? d_gnt : i_gnt;
    end while (!g && n < 50);
    if (!g) chk(name, {31'b0, g}, 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((gq.size() + cq.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, gq.size() + cq.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Memory model: ready arrives lat cycles after mem_req rises. Read data is
  // poisoned whenever ready is low.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      rcnt      = 0;
    end else if (rcnt >= lat) begin
      mem_ready = 1'b1;
      mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
      if (mem_we) mem[mem_addr] = mem_wdata;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      rcnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (d_gnt || i_gnt) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {30'b0, d_gnt, i_gnt}, 32'd0);
        end else begin
          mg = gq.pop_front();
          chk("gnt_port", {31'b0, d_gnt}, {31'b0, mg.is_d});
          chk("gnt_both", {31'b0, d_gnt & i_gnt}, 32'd0);
          chk("gnt_mem_req", {31'b0, mem_req}, 32'd1);
          chk("gnt_mem_we", {31'b0, mem_we}, {31'b0, mg.we});
          chk("gnt_mem_addr", mem_addr, mg.addr);
          if (mg.is_d) chk("gnt_mem_wdata", mem_wdata, mg.wdata);
        end
      end
      if (d_valid || i_valid) begin
        if (cq.size() == 0) begin
          chk("unexpected_valid", {30'b0, d_valid, i_valid}, 32'd0);
        end else begin
          mc = cq.pop_front();
          chk("valid_port", {30'b0, d_valid, i_valid}, mc.is_d ? 32'd2 : 32'd1);
          chk("valid_rdata", mc.is_d ? d_rdata : i_rdata, mc.rdata);
          chk("valid_err", {31'b0, err}, {31'b0, mc.err});
        end
      end else if (err) begin
        chk("err_without_valid", {31'b0, err}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem[32'h100] = 32'h0000_1234;
    mem[32'h200] = 32'hDEAD_BEEF;
    mem[32'h204] = 32'h0000_0013;
    mem[32'h300] = 32'h3333_0000;
    mem[32'h400] = 32'h4444_0001;
    mem[32'h500] = 32'h55AA_55AA;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_gnt", {30'b0, d_gnt, i_gnt}, 32'd0);
    chk("rst_valid", {30'b0, d_valid, i_valid}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single load at minimum latency
    lat = 0;
    exp_gnt(1, 0, 32'h100, 32'h0);
    exp_cmp(1, 32'h0000_1234, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
    @(posedge clk); #1;
    chk("t1_d_gnt_cycle1", {31'b0, d_gnt}, 32'd1);
    d_req = 1'b0;
    @(posedge clk); #1;
    chk("t1_d_valid_cycle2", {31'b0, d_valid}, 32'd1);
    chk("t1_d_rdata", d_rdata, 32'h0000_1234);
    drain("t1_drain");

    // 2: simultaneous requests -> data first, fetch on the next IDLE
    exp_gnt(1, 0, 32'h200, 32'h0);
    exp_gnt(0, 0, 32'h204, 32'h0);
    exp_cmp(1, 32'hDEAD_BEEF, 0);
    exp_cmp(0, 32'h0000_0013, 0);
    d_req = 1'b1; d_addr = 32'h200;
    i_req = 1'b1; i_addr = 32'h204;
    wait_gnt(1, "t2_d_gnt");
    d_req = 1'b0;
    wait_gnt(0, "t2_i_gnt");
    i_req = 1'b0;
    drain("t2_drain");

    // 3: starvation -> four data grants, a forced fetch, then data again
    for (int k = 0; k < 4; k++) begin
      exp_gnt(1, 0, 32'h300, 32'h0);
      exp_cmp(1, 32'h3333_0000, 0);
    end
    exp_gnt(0, 0, 32'h400, 32'h0);
    exp_cmp(0, 32'h4444_0001, 0);
    exp_gnt(1, 0, 32'h300, 32'h0);
    exp_cmp(1, 32'h3333_0000, 0);
    d_req = 1'b1; d_addr = 32'h300;
    i_req = 1'b1; i_addr = 32'h400;
    for (int k = 0; k < 4; k++) wait_gnt(1, "t3_d_gnt");
    wait_gnt(0, "t3_i_gnt");
    i_req = 1'b0;
    wait_gnt(1, "t3_d_gnt_after");
    d_req = 1'b0;
    drain("t3_drain");

    // 4: store with a 3-cycle-late ready; d_rdata keeps the last load value
    lat = 3;
    exp_gnt(1, 1, 32'h104, 32'hCAFE_F00D);
    exp_cmp(1, 32'h3333_0000, 0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'hCAFE_F00D;
    wait_gnt(1, "t4_d_gnt");
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
    n = 0;
    while (mem_req && n < 20) begin
      chk("t4_stable_we", {31'b0, mem_we}, 32'd1);
      chk("t4_stable_addr", mem_addr, 32'h104);
      chk("t4_stable_wdata", mem_wdata, 32'hCAFE_F00D);
      n++;
      @(posedge clk); #1;
    end
    chk("t4_mem_req_cycles", n, 32'd4);
    drain("t4_drain");

    // 5: reset while BUSY_D, then a fetch is served normally
    lat = 50;
    exp_gnt(1, 0, 32'h108, 32'h0);
    d_req = 1'b1; d_addr = 32'h108;
    wait_gnt(1, "t5_d_gnt");
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_mem_req_async", {31'b0, mem_req}, 32'd0);
    chk("t5_no_d_valid", {31'b0, d_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain("t5_reset_drain");
    lat = 1;
    exp_gnt(0, 0, 32'h500, 32'h0);
    exp_cmp(0, 32'h55AA_55AA, 0);
    i_req = 1'b1; i_addr = 32'h500;
    wait_gnt(0, "t5_i_gnt");
    i_req = 1'b0;
    drain("t5_drain");

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: memory never answers -> abort after 8 BUSY cycles
    lat = 1000;
    exp_gnt(0, 0, 32'h600, 32'h0);
    exp_cmp(0, 32'h0, 1);
    i_req = 1'b1; i_addr = 32'h600;
    wait_gnt(0, "t6_i_gnt");
    i_req = 1'b0;
    n = 0;
    while (!i_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_abort_cycles", n, 32'd8);
    chk("t6_err", {31'b0, err}, 32'd1);
    drain("t6_drain");
    lat = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
